// File: rtl/axi2mem_pkg.sv
// Shared types and helpers for the axi2mem TCDM read buffer.
// The tag id field is sized for the widest supported ID; narrower IDs are zero-extended.
package axi2mem_pkg;

  localparam int unsigned AXI2MEM_MAX_ID_WIDTH = 16;

  typedef struct packed {
    logic [AXI2MEM_MAX_ID_WIDTH-1:0] id;
    logic                            last;
  } axi2mem_tag_t;

  function automatic int unsigned axi2mem_cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/axi2mem_rd_fifo.sv
// Synchronous FIFO with occupancy count; storage enable models a test-mode clock gate.
module axi2mem_rd_fifo
  import axi2mem_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  test_en_i,
  input  logic                                  push_i,
  input  logic [WIDTH-1:0]                      data_i,
  input  logic                                  pop_i,
  output logic [WIDTH-1:0]                      data_o,
  output logic                                  full_o,
  output logic                                  empty_o,
  output logic [axi2mem_cnt_width(DEPTH)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = axi2mem_cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             clk_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // In test mode the gate is forced open, so the addressed entry reloads itself.
  assign clk_en = push_i | test_en_i;

  always_ff @(posedge clk_i) begin
    if (clk_en) mem[wr_ptr] <= push_i ? data_i : mem[wr_ptr];
  end

  assign data_o  = mem[rd_ptr];
  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign count_o = cnt;

endmodule

// File: rtl/axi2mem_tcdm_rd_buf.sv
// TCDM read-port adapter: credit-limited issue, in-order tagged responses.
// Define AXI2MEM_RD_BYPASS_EN for a zero-cycle path from TCDM data to the response port.
module axi2mem_tcdm_rd_buf
  import axi2mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 6,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 test_en_i,
  input  logic                                 trans_req_i,
  output logic                                 trans_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                trans_add_i,
  input  logic [DATA_WIDTH/8-1:0]              trans_be_i,
  input  logic [ID_WIDTH-1:0]                  trans_id_i,
  input  logic                                 trans_last_i,
  output logic                                 data_req_o,
  input  logic                                 data_gnt_i,
  output logic [DATA_WIDTH-1:0]                data_dat_o,
  output logic [ID_WIDTH-1:0]                  data_id_o,
  output logic                                 data_last_o,
  output logic                                 tcdm_req_o,
  input  logic                                 tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]                tcdm_add_o,
  output logic                                 tcdm_we_o,
  output logic [DATA_WIDTH/8-1:0]              tcdm_be_o,
  output logic [DATA_WIDTH-1:0]                tcdm_wdata_o,
  input  logic [DATA_WIDTH-1:0]                tcdm_r_rdata_i,
  input  logic                                 tcdm_r_valid_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned CW = axi2mem_cnt_width(MAX_OUTSTANDING);

  axi2mem_tag_t        tag_push, tag_head;
  logic                tag_full, tag_empty;
  logic [CW-1:0]       tag_count, data_count;
  logic [DATA_WIDTH-1:0] data_head;
  logic                data_full, data_empty;
  logic                issue, pop, pending, rvalid_ok, data_push, data_pop;

  // The tag FIFO occupancy is exactly the credit count: pushed on issue, popped on response.
  assign tcdm_req_o    = trans_req_i & ~tag_full & rst_ni;
  assign issue         = tcdm_req_o & tcdm_gnt_i;
  assign trans_gnt_o   = issue;
  assign tcdm_add_o    = rst_ni ? trans_add_i : '0;
  assign tcdm_be_o     = tcdm_req_o ? trans_be_i : '0;
  assign tcdm_we_o     = 1'b1;
  assign tcdm_wdata_o  = '0;
  assign outstanding_o = tag_count;

  // Reads issued but not yet returned = tags held minus beats buffered.
  assign pending   = (tag_count != data_count);
  assign rvalid_ok = tcdm_r_valid_i & pending;

  always_comb begin
    tag_push      = '0;
    tag_push.id   = AXI2MEM_MAX_ID_WIDTH'(trans_id_i);
    tag_push.last = trans_last_i;
  end

  always_comb begin
    data_push  = rvalid_ok;
    data_req_o = ~data_empty;
    data_dat_o = data_empty ? '0 : data_head;
`ifdef AXI2MEM_RD_BYPASS_EN
    if (data_empty && rvalid_ok) begin
      data_req_o = 1'b1;
      data_dat_o = tcdm_r_rdata_i;
      data_push  = ~data_gnt_i;
    end
`endif
    pop         = data_req_o & data_gnt_i;
    data_pop    = pop & ~data_empty;
    data_id_o   = data_req_o ? ID_WIDTH'(tag_head.id) : '0;
    data_last_o = data_req_o & tag_head.last;
  end

  axi2mem_rd_fifo #(
    .WIDTH ($bits(axi2mem_tag_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) i_tag_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .test_en_i (test_en_i),
    .push_i    (issue),
    .data_i    (tag_push),
    .pop_i     (pop),
    .data_o    (tag_head),
    .full_o    (tag_full),
    .empty_o   (tag_empty),
    .count_o   (tag_count)
  );

  axi2mem_rd_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) i_data_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .test_en_i (test_en_i),
    .push_i    (data_push),
    .data_i    (tcdm_r_rdata_i),
    .pop_i     (data_pop),
    .data_o    (data_head),
    .full_o    (data_full),
    .empty_o   (data_empty),
    .count_o   (data_count)
  );

  a_rvalid_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(tcdm_r_valid_i && !pending)) else $error("TCDM read data with no read pending");
  a_data_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(data_push && data_full)) else $error("data FIFO overflow");
  a_tag_present: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(data_req_o && tag_empty)) else $error("response without tag");

endmodule
